arb_client_requester: RTL
=========================

# arb_client_requester

- Client-side counterpart of the 4-way round-robin arbiter.
- Holds a pending-job count per client and drives `request[3:0]` toward the arbiter.
- When a client is granted, it runs a fixed-length burst on a shared beat bus, then releases the request for one cycle so the arbiter can rotate.
- Flags queue overflow and grant-protocol violations.

## Interface

Parameters:
- `BURST_LEN`, default 4 — beats per job, legal range 1..16.
- `QMAX`, default 7 — maximum pending jobs per client, legal range 1..15.

Ports:
- `clk` — in, 1 — rising-edge clock.
- `rst` — in, 1 — reset, asynchronous and active-low.
- `job` — in, 4 — per-client enqueue strobe; each set bit adds one job that cycle.
- `grant` — in, 4 — grant from the arbiter; expected one-hot or zero.
- `request` — out, 4 — request to the arbiter.
- `beat_valid` — out, 1 — a data beat is on the shared bus this cycle.
- `beat_owner` — out, 2 — index of the client owning the current beat.
- `beat_idx` — out, 4 — beat number within the burst, 0..BURST_LEN-1.
- `job_done` — out, 4 — one-cycle pulse when a client's job completes.
- `overflow` — out, 4 — one-cycle pulse when a job is dropped because that client's queue is full.
- `proto_err` — out, 1 — one-cycle pulse on a grant-protocol violation.

## Operation

Pending counters:
- One 4-bit counter `pend[i]` per client.
- `job[i]` increments `pend[i]`.
- Completion of a burst owned by client i decrements `pend[i]`.
- If increment and decrement coincide on the same client, the count is unchanged and no overflow is raised, even when `pend[i]==QMAX`.
- `job[i]` with `pend[i]==QMAX` and no coincident decrement: job dropped, `overflow[i]` pulses the next cycle.

Request generation:
- `request[i] = (pend[i]!=0) && !(state==RELEASE && owner==i)`.
- `request` is decoded from registers only; there is no combinational path from `grant` or `job`.

FSM states: IDLE, BURST, RELEASE.
- **IDLE:**
  - `grant` one-hot with `grant[i] && request[i]` → BURST, `owner=i`, `beat_idx=0`.
  - `grant==0` → stay in IDLE.
  - `grant` not one-hot, or granting a client with `request[i]==0` → ignored, `proto_err` pulses, stay in IDLE.
- **BURST:**
  - `beat_valid=1`; `beat_owner=owner`; `beat_idx` increments each cycle.
  - `grant[owner]` must stay high during every burst cycle.
  - If `grant[owner]` drops → abort: `proto_err` pulses, `pend` unchanged, go to IDLE.
  - Last beat (`beat_idx==BURST_LEN-1`) with grant held → decrement `pend[owner]`, `job_done[owner]` pulses, go to RELEASE.
- **RELEASE:**
  - `request[owner]` is forced low for exactly one cycle; then IDLE.
  - `grant` seen in RELEASE is ignored with no error.

Other rules:
- Only one burst is active at a time; `job` strobes are still accepted during a burst.
- `beat_idx` and `beat_owner` hold their last value when `beat_valid==0`.
- `beat_idx` wraps only via the state transition, never by modulo counting.

## Timing

Reset (`rst` low), asynchronous and immediate:
- state=IDLE.
- All `pend` = 0.
- `owner` = 0.
- `request` = 0, `beat_valid` = 0, `beat_owner` = 0, `beat_idx` = 0, `job_done` = 0, `overflow` = 0, `proto_err` = 0.
- Reset during BURST discards the burst silently: no `job_done`, no `proto_err`.

Job to request:
- `job[i]` sampled at edge k → `request[i]` high from cycle k+1, provided `pend[i]` was 0 and client i is not in RELEASE.

Grant to burst:
- Grant sampled at edge k in IDLE → first beat (`beat_idx=0`) in cycle k+1.
- Beats occupy cycles k+1 .. k+BURST_LEN.
- `job_done` and RELEASE are both in cycle k+BURST_LEN+1.
- IDLE returns in cycle k+BURST_LEN+2.
- Per-job bus occupancy: BURST_LEN+2 cycles, including the grant-sample cycle.

Pulse outputs:
- `job_done`, `overflow` and `proto_err` are registered, one cycle wide, and fire in the cycle after the triggering edge condition.

Re-request after release:
- A client with `pend>0` after a job re-asserts `request` in the first IDLE cycle after RELEASE.

## Test plan

- **Reset values:** reset asserted mid-BURST of client 2 → all outputs 0 immediately; `pend` cleared; no `job_done` after reset release.
- **Single job:** `job=0001` for one cycle, then `grant=0001` held → `request=0001`; 4 beats with `beat_idx` 0..3 and `beat_owner=0`; `job_done=0001` next cycle; `request` low one cycle then stays 0.
- **Rotation:** `job=1010` once; grant client 1 then client 3, each held through its burst → two 4-beat bursts with owners 1 then 3; `request[1]` drops during RELEASE; `job_done` pulses `0010` then `1000`.
- **Queue full:** 8 pulses on `job[2]` with no grant → `pend[2]=7`, `overflow[2]` pulses once. Then, in the final beat of client 2's burst, apply `job[2]` → no overflow, `pend[2]` stays 7.
- **Grant withdrawn:** `grant[0]` drops at `beat_idx=2` → `proto_err` pulses, no `job_done`, `pend[0]` unchanged, `request[0]` still high in IDLE.
- **Illegal grant:** `grant=0110` in IDLE, or `grant=0100` with `request[2]=0` → `proto_err` pulses, `beat_valid` stays 0.

Source files
------------

// File: rtl/arb_client_requester_if.sv
// Bundle of signals between the client requester, the arbiter and the shared beat bus.
// The master modport is the requester's side of the bundle.
interface arb_client_requester_if;
    logic [3:0] job;
    logic [3:0] grant;
    logic [3:0] request;
    logic       beat_valid;
    logic [1:0] beat_owner;
    logic [3:0] beat_idx;
    logic [3:0] job_done;
    logic [3:0] overflow;
    logic       proto_err;

    modport master (
        input  job, grant,
        output request, beat_valid, beat_owner, beat_idx, job_done, overflow, proto_err
    );

    modport slave (
        output job, grant,
        input  request, beat_valid, beat_owner, beat_idx, job_done, overflow, proto_err
    );
endinterface

// File: rtl/arb_client_requester.sv
// Client side of a 4-way round-robin arbiter: per-client pending-job counters,
// a request vector, and a fixed-length burst on the shared beat bus for each grant.
module arb_client_requester #(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned QMAX      = 7
) (
    input logic                    clk,
    input logic                    rst,
    arb_client_requester_if.master bus
);
    typedef enum logic [1:0] {IDLE, BURST, RELEASE} state_t;

    localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);
    localparam logic [3:0] PEND_MAX  = 4'(QMAX);

    state_t     state;
    logic [3:0] pend [4];
    logic [1:0] owner;
    logic [3:0] beat_idx;
    logic       beat_valid;
    logic [3:0] job_done;
    logic [3:0] overflow;
    logic       proto_err;

    logic [3:0] request;
    logic [3:0] dec;
    logic [1:0] grant_idx;
    logic       grant_onehot;
    logic       grant_held;
    logic       last_beat;

    always_comb begin
        request   = '0;
        grant_idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            request[i] = (pend[i] != '0) && !(state == RELEASE && owner == 2'(i));
            if (bus.grant[i]) grant_idx = 2'(i);
        end
        grant_onehot = (bus.grant != '0) && ((bus.grant & (bus.grant - 4'd1)) == '0);
        grant_held   = bus.grant[owner];
        last_beat    = (beat_idx == LAST_BEAT);
        dec          = (state == BURST && grant_held && last_beat) ? (4'b0001 << owner) : '0;
    end

    // A job and a completion on the same client cancel out, so a full queue can still accept it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 4; i++) pend[i] <= '0;
            overflow <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                overflow[i] <= 1'b0;
                if (bus.job[i] && !dec[i]) begin
                    if (pend[i] == PEND_MAX) overflow[i] <= 1'b1;
                    else                     pend[i]     <= pend[i] + 4'd1;
                end else if (!bus.job[i] && dec[i]) begin
                    pend[i] <= pend[i] - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= '0;
            beat_idx   <= '0;
            beat_valid <= 1'b0;
            job_done   <= '0;
            proto_err  <= 1'b0;
        end else begin
            job_done  <= '0;
            proto_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.grant != '0) begin
                        if (grant_onehot && (bus.grant & request) != '0) begin
                            state      <= BURST;
                            owner      <= grant_idx;
                            beat_idx   <= '0;
                            beat_valid <= 1'b1;
                        end else begin
                            proto_err <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    if (!grant_held) begin
                        proto_err  <= 1'b1;
                        beat_valid <= 1'b0;
                        state      <= IDLE;
                    end else if (last_beat) begin
                        job_done   <= dec;
                        beat_valid <= 1'b0;
                        state      <= RELEASE;
                    end else begin
                        beat_idx <= beat_idx + 4'd1;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.request    = request;
    assign bus.beat_valid = beat_valid;
    assign bus.beat_owner = owner;
    assign bus.beat_idx   = beat_idx;
    assign bus.job_done   = job_done;
    assign bus.overflow   = overflow;
    assign bus.proto_err  = proto_err;
endmodule
